// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the decode/execute boundary: register-number, data and
// ALU-opcode widths plus the ALU opcode encodings used by decode, GPRF and EX.
package id_ex_stage_pkg;

  localparam int unsigned REG_NUM_SIZE = 5;
  localparam int unsigned REG_SIZE     = 32;
  localparam int unsigned ALU_OP_SIZE  = 4;

  typedef logic [REG_NUM_SIZE-1:0] reg_num_t;
  typedef logic [REG_SIZE-1:0]     word_t;
  typedef logic [ALU_OP_SIZE-1:0]  alu_op_t;

  typedef enum logic [ALU_OP_SIZE-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of every non-clock/reset signal crossing the ID/EX stage boundary:
// decoded instruction fields, GPRF read port, MEM-stage result, pipeline
// control (flush/freeze/stall) and the ID/EX register outputs.
// slave  : the id_ex_stage block.
// master : the surrounding pipeline (decode, GPRF, MEM, EX).
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic     id_valid;
  reg_num_t id_rs1;
  reg_num_t id_rs2;
  reg_num_t id_rd;
  word_t    id_imm;
  word_t    id_pc;
  alu_op_t  id_alu_op;
  logic     id_is_load;
  logic     id_reg_we;

  reg_num_t rf_rn1;
  reg_num_t rf_rn2;
  word_t    rf_d1;
  word_t    rf_d2;

  reg_num_t mem_rd;
  logic     mem_we;
  word_t    mem_data;

  logic     flush;
  logic     freeze;
  logic     id_stall;

  logic     ex_valid;
  word_t    ex_rs1_val;
  word_t    ex_rs2_val;
  reg_num_t ex_rd;
  word_t    ex_imm;
  word_t    ex_pc;
  alu_op_t  ex_alu_op;
  logic     ex_is_load;
  logic     ex_reg_we;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_imm, id_pc, id_alu_op,
           id_is_load, id_reg_we, rf_d1, rf_d2, mem_rd, mem_we, mem_data,
           flush, freeze,
    input  rf_rn1, rf_rn2, id_stall, ex_valid, ex_rs1_val, ex_rs2_val,
           ex_rd, ex_imm, ex_pc, ex_alu_op, ex_is_load, ex_reg_we
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_imm, id_pc, id_alu_op,
           id_is_load, id_reg_we, rf_d1, rf_d2, mem_rd, mem_we, mem_data,
           flush, freeze,
    output rf_rn1, rf_rn2, id_stall, ex_valid, ex_rs1_val, ex_rs2_val,
           ex_rd, ex_imm, ex_pc, ex_alu_op, ex_is_load, ex_reg_we
  );

endinterface

// File: rtl/id_ex_stage_operand_bypass.sv
// Combinational source-operand select for one register read.
//   rs       : source register number
//   rf_data  : GPRF read data for rs
//   mem_rd/mem_we/mem_data : result of the instruction currently in MEM
//   operand  : x0 -> 0, MEM hit -> mem_data, else GPRF data
// WB needs no path here: the GPRF writes on the falling edge, so its data is
// already current before the capture edge.
module operand_bypass
  import id_ex_stage_pkg::*;
(
  input  reg_num_t rs,
  input  word_t    rf_data,
  input  reg_num_t mem_rd,
  input  logic     mem_we,
  input  word_t    mem_data,
  output word_t    operand
);

  // Testing rs == 0 first also guarantees that mem_rd == 0 never bypasses.
  always_comb begin
    operand = rf_data;
    if (rs == '0) begin
      operand = '0;
    end else if (mem_we && (mem_rd == rs)) begin
      operand = mem_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: drives the GPRF read addresses, selects operands
// (MEM-stage bypass over GPRF data), detects load-use hazards and holds the
// ID/EX register under flush/freeze/bubble control.
//   clk : core clock, rising-edge state updates
//   rst : asynchronous, active-low reset
//   bus : id_ex_stage_if.slave carrying decode, GPRF, MEM, control, ex_* signals
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  word_t rs1_val;
  word_t rs2_val;
  logic  lu;

  assign bus.rf_rn1 = bus.id_rs1;
  assign bus.rf_rn2 = bus.id_rs2;

  operand_bypass u_bypass_rs1 (
    .rs       (bus.id_rs1),
    .rf_data  (bus.rf_d1),
    .mem_rd   (bus.mem_rd),
    .mem_we   (bus.mem_we),
    .mem_data (bus.mem_data),
    .operand  (rs1_val)
  );

  operand_bypass u_bypass_rs2 (
    .rs       (bus.id_rs2),
    .rf_data  (bus.rf_d2),
    .mem_rd   (bus.mem_rd),
    .mem_we   (bus.mem_we),
    .mem_data (bus.mem_data),
    .operand  (rs2_val)
  );

  // A load in EX whose destination is read by decode. Once the bubble is
  // captured ex_valid drops, so the stall self-terminates after one cycle.
  always_comb begin
    lu = bus.ex_valid && bus.ex_is_load && bus.ex_reg_we && (bus.ex_rd != '0)
      && bus.id_valid && ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
  end

  assign bus.id_stall = ~bus.flush & (bus.freeze | lu);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ex_valid   <= 1'b0;
      bus.ex_rs1_val <= '0;
      bus.ex_rs2_val <= '0;
      bus.ex_rd      <= '0;
      bus.ex_imm     <= '0;
      bus.ex_pc      <= '0;
      bus.ex_alu_op  <= '0;
      bus.ex_is_load <= 1'b0;
      bus.ex_reg_we  <= 1'b0;
    end else if (bus.flush) begin
      bus.ex_valid   <= 1'b0;
      bus.ex_is_load <= 1'b0;
      bus.ex_reg_we  <= 1'b0;
    end else if (!bus.freeze) begin
      if (lu) begin
        bus.ex_valid   <= 1'b0;
        bus.ex_is_load <= 1'b0;
        bus.ex_reg_we  <= 1'b0;
      end else begin
        // An invalid decode slot is captured as a bubble as well, so side
        // effects are qualified by id_valid.
        bus.ex_valid   <= bus.id_valid;
        bus.ex_rs1_val <= rs1_val;
        bus.ex_rs2_val <= rs2_val;
        bus.ex_rd      <= bus.id_rd;
        bus.ex_imm     <= bus.id_imm;
        bus.ex_pc      <= bus.id_pc;
        bus.ex_alu_op  <= bus.id_alu_op;
        bus.ex_is_load <= bus.id_is_load & bus.id_valid;
        bus.ex_reg_we  <= bus.id_reg_we & bus.id_valid;
      end
    end
  end

endmodule
